tdc_multi_ch: RTL and testbench
===============================

Name: tdc_multi_ch

Overview:
- Multi-channel successor to the single-input TDC front end.
- Measures the interval, in clk_100m cycles, between consecutive qualifying edges on each of NUM_CH asynchronous inputs.
- Each measurement becomes a tagged record in a shared FIFO, presented on a valid/ready stream to the UART packer.
- Adds edge-mode select, counter-overflow flagging, per-channel holding, round-robin arbitration, backpressure and drop counting.

Parameters:
- NUM_CH, 4, number of input channels (>=2); CH_W = clog2(NUM_CH).
- CNT_W, 24, interval counter width in bits.
- FIFO_DEPTH, 16, record FIFO depth (power of two, >=4).
- SYNC_STAGES, 2, synchroniser flops per input (>=2).

Ports:
- clk_100m  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- signal_in  in  NUM_CH  asynchronous timing inputs.
- enable  in  1  1 = measure; 0 = disarm all channels.
- edge_mode  in  2  00 rising, 01 falling, 10 both, 11 treated as rising.
- m_data  out  CNT_W+CH_W+1  record {ovf, ch, interval}.
- m_valid  out  1  record available.
- m_ready  in  1  consumer accepts record.
- fifo_level  out  clog2(FIFO_DEPTH)+1  entries held in FIFO.
- drop_cnt  out  16  records lost; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, sync release via clk_100m): all outputs 0; counters, armed flags, holding registers, FIFO pointers and round-robin pointer cleared.
- Synchroniser:
  - SYNC_STAGES flops per channel, then one history flop.
  - An edge event is the cycle in which the synchronised value differs from history and matches edge_mode.
  - Fixed latency, identical on all channels, so intervals between synchronous stimuli are exact.
- Per-channel counter:
  - On an edge event, cnt <= 1; otherwise cnt <= cnt+1.
  - Saturates at 2^CNT_W-1 and sets a sticky ovf.
  - Edge events in cycles a and b capture interval = b-a.
- Arming:
  - The first edge event after reset or after enable rises only arms the channel and restarts the counter; no record is produced.
  - Every later edge event produces a record {ovf, ch, cnt} and clears ovf.
- Holding register:
  - One entry per channel, loaded at the end of the edge-event cycle.
  - If the holding register is still full at a new edge event, that record is dropped and drop_cnt increments; the counter still restarts.
- Arbiter:
  - Round robin over full holding registers; at most one FIFO push per cycle, only when the FIFO is not full.
  - The pointer moves to granted ch+1, starting at ch0 after reset.
  - Granting frees that holding register in the same cycle.
- FIFO:
  - First-word-fall-through: m_valid = !empty, m_data = head.
  - Pop on m_valid && m_ready.
  - Push and pop in the same cycle are both honoured; fifo_level is unchanged.
  - A full FIFO blocks pushes, with no overwrite.
- Latency: edge event in cycle k with empty FIFO and idle arbiter -> m_valid high in cycle k+2.
- enable low:
  - Clears armed flags, counters, ovf and holding registers the next cycle.
  - FIFO contents and drop_cnt are retained and drain normally.
- edge_mode must only change while enable = 0. A mid-run change takes effect the next cycle without corrupting state.
- m_data is stable while m_valid && !m_ready.

Test Plan:
1. ch0 rising, rising edges 20 cycles apart, edge_mode=00 -> one record {0,0,20}; m_valid exactly 2 cycles after the 2nd edge event; no record after the 1st.
2. edge_mode=10, ch1 rises then falls 10 cycles later -> record {0,1,10}.
3. All 4 channels armed together, then second edges simultaneous 40 cycles later -> records {0,0,40},{0,1,40},{0,2,40},{0,3,40} on consecutive cycles in that order.
4. CNT_W=8, ch2 edges 300 cycles apart -> record {1,2,255}; next edge 5 cycles later -> {0,2,5}.
5. m_ready=0, 19 edges on ch0 at 10-cycle spacing -> fifo_level=16, holding full, drop_cnt=1; raise m_ready -> 17 records of interval 10 delivered in order, fifo_level reaches 0.
6. rst_n low asynchronously with 5 records queued -> m_valid, fifo_level and drop_cnt 0 without a clock edge; after release, the 1st edge produces no record.

Source files
------------

// File: rtl/tdc_multi_ch.sv
// ============================================================================
//  Module   : tdc_multi_ch
//  Purpose  : Multi-channel time-to-digital front end. Per-channel interval
//             counters feed a round-robin arbiter and a FWFT record FIFO.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tdc_multi_ch #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 24,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                clk_100m,
    input  logic                                rst_n,
    input  logic [NUM_CH-1:0]                   signal_in,
    input  logic                                enable,
    input  logic [1:0]                          edge_mode,
    output logic [CNT_W+$clog2(NUM_CH):0]       m_data,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
    output logic [15:0]                         drop_cnt
);

    localparam int CH_W   = $clog2(NUM_CH);
    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = ADDR_W + 1;
    localparam int DATA_W = CNT_W + CH_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Reset is asserted asynchronously but released on a clock edge.
    logic [1:0] r_rst_pipe;
    logic       w_rst_n;

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) r_rst_pipe <= 2'b00;
        else        r_rst_pipe <= {r_rst_pipe[0], 1'b1};
    end
    assign w_rst_n = r_rst_pipe[1];

    logic [NUM_CH-1:0] w_hold_v;
    logic [NUM_CH-1:0] w_hold_ovf;
    logic [NUM_CH-1:0] w_drop;
    logic [NUM_CH-1:0] w_grant;
    logic [CNT_W-1:0]  w_hold_cnt [NUM_CH];
    logic [CH_W-1:0]   w_grant_idx;
    logic [CH_W-1:0]   r_rr_ptr;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_push_data;

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic                   r_hist;
            logic                   r_armed;
            logic                   r_ovf;
            logic [CNT_W-1:0]       r_cnt;
            logic                   r_hold_v;
            logic                   r_hold_ovf;
            logic [CNT_W-1:0]       r_hold_cnt;
            logic                   w_sync;
            logic                   w_match;
            logic                   w_edge;
            logic                   w_rec;

            assign w_sync = r_sync[SYNC_STAGES-1];

            always_comb begin
                w_match = w_sync;
                case (edge_mode)
                    2'b01:   w_match = !w_sync;
                    2'b10:   w_match = 1'b1;
                    default: w_match = w_sync;
                endcase
            end

            assign w_edge = enable && (w_sync != r_hist) && w_match;
            assign w_rec  = w_edge && r_armed;
            // A grant in the same cycle frees the slot, so only a stuck entry drops.
            assign w_drop[c] = w_rec && r_hold_v && !w_grant[c];

            always_ff @(posedge clk_100m or negedge w_rst_n) begin
                if (!w_rst_n) begin
                    r_sync <= '0;
                    r_hist <= 1'b0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], signal_in[c]};
                    r_hist <= w_sync;
                end
            end

            always_ff @(posedge clk_100m or negedge w_rst_n) begin
                if (!w_rst_n) begin
                    r_armed    <= 1'b0;
                    r_ovf      <= 1'b0;
                    r_cnt      <= '0;
                    r_hold_v   <= 1'b0;
                    r_hold_ovf <= 1'b0;
                    r_hold_cnt <= '0;
                end else if (!enable) begin
                    r_armed  <= 1'b0;
                    r_ovf    <= 1'b0;
                    r_cnt    <= '0;
                    r_hold_v <= 1'b0;
                end else begin
                    if (w_edge) begin
                        r_cnt   <= CNT_ONE;
                        r_ovf   <= 1'b0;
                        r_armed <= 1'b1;
                    end else if (r_cnt == CNT_MAX) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end

                    if (w_rec && !w_drop[c]) begin
                        r_hold_v   <= 1'b1;
                        r_hold_ovf <= r_ovf;
                        r_hold_cnt <= r_cnt;
                    end else if (w_grant[c]) begin
                        r_hold_v <= 1'b0;
                    end
                end
            end

            assign w_hold_v[c]   = r_hold_v;
            assign w_hold_ovf[c] = r_hold_ovf;
            assign w_hold_cnt[c] = r_hold_cnt;
        end
    endgenerate

    function automatic int rr_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_CH) s = s - NUM_CH;
        return s;
    endfunction

    always_comb begin
        w_grant     = '0;
        w_grant_idx = '0;
        w_push      = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_push && !w_full && w_hold_v[rr_idx(int'(r_rr_ptr), i)]) begin
                w_push                              = 1'b1;
                w_grant[rr_idx(int'(r_rr_ptr), i)]  = 1'b1;
                w_grant_idx                         = CH_W'(rr_idx(int'(r_rr_ptr), i));
            end
        end
    end

    assign w_push_data = {w_hold_ovf[w_grant_idx], w_grant_idx, w_hold_cnt[w_grant_idx]};

    logic [16:0] w_drop_next;
    logic [15:0] r_drop_cnt;

    always_comb begin
        w_drop_next = {1'b0, r_drop_cnt};
        for (int i = 0; i < NUM_CH; i++) begin
            w_drop_next = w_drop_next + 17'(w_drop[i]);
        end
        if (w_drop_next > 17'h0FFFF) w_drop_next = 17'h0FFFF;
    end

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_wptr;
    logic [ADDR_W-1:0] r_rptr;
    logic [LVL_W-1:0]  r_level;

    assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty = (r_level == '0);
    assign w_pop   = !w_empty && m_ready;

    always_ff @(posedge clk_100m) begin
        if (w_push) r_mem[r_wptr] <= w_push_data;
    end

    always_ff @(posedge clk_100m or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_drop_cnt <= '0;
            r_rr_ptr   <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
        end else begin
            r_drop_cnt <= w_drop_next[15:0];
            if (w_push) begin
                r_rr_ptr <= (w_grant_idx == CH_W'(NUM_CH - 1)) ? '0 : w_grant_idx + 1'b1;
                r_wptr   <= r_wptr + 1'b1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Head is masked while empty so the stream reads zero out of reset.
    assign m_valid    = !w_empty;
    assign m_data     = w_empty ? '0 : r_mem[r_rptr];
    assign fifo_level = r_level;
    assign drop_cnt   = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tdc_multi_ch.sv
// ============================================================================
//  Module   : tb_tdc_multi_ch
//  Purpose  : Scoreboard bench for tdc_multi_ch (NUM_CH=4, CNT_W=8).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tdc_multi_ch;

    localparam int DW = 11;

    logic          clk_100m = 1'b0;
    logic          rst_n = 1'b1;
    logic [3:0]    signal_in = '0;
    logic          enable = 1'b0;
    logic [1:0]    edge_mode = 2'b00;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [4:0]    fifo_level;
    logic [15:0]   drop_cnt;

    int tests = 0;
    int fails = 0;
    int pop_count = 0;
    logic [DW-1:0] exp_q [$];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    tdc_multi_ch #(
        .NUM_CH     (4),
        .CNT_W      (8),
        .FIFO_DEPTH (16),
        .SYNC_STAGES(2)
    ) dut (
        .clk_100m  (clk_100m),
        .rst_n     (rst_n),
        .signal_in (signal_in),
        .enable    (enable),
        .edge_mode (edge_mode),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .fifo_level(fifo_level),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk_100m = ~clk_100m;

    function automatic logic [DW-1:0] rec(input logic ovf, input logic [1:0] ch, input logic [7:0] iv);
        return {ovf, ch, iv};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100m);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] mode);
        enable    = 1'b0;
        signal_in = '0;
        m_ready   = 1'b1;
        tick(4);
        rst_n = 1'b0;
        tick(2);
        edge_mode = mode;
        rst_n = 1'b1;
        tick(4);
        enable = 1'b1;
        tick(2);
    endtask

    // Monitor: pops the scoreboard on every accepted record.
    always @(negedge clk_100m) begin
        if (prev_stall && m_valid)
            check("stall_stable", 32'(m_data), 32'(prev_data));
        if (m_valid && m_ready) begin
            pop_count++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_record: got %0h expected none", m_data);
            end else begin
                check("record", 32'(m_data), 32'(exp_q.pop_front()));
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        #2 rst_n = 1'b0;
        tick(2);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_fifo_level", 32'(fifo_level), 0);
        check("rst_drop_cnt", 32'(drop_cnt), 0);
        check("rst_m_data", 32'(m_data), 0);
        rst_n = 1'b1;
        tick(4);
        enable = 1'b1;
        tick(2);

        // 1: rising edges 20 cycles apart on ch0
        signal_in[0] = 1'b1;
        tick(5);
        signal_in[0] = 1'b0;
        tick(15);
        check("t1_no_rec_after_arm", 32'(fifo_level), 0);
        exp_q.push_back(rec(1'b0, 2'd0, 8'd20));
        signal_in[0] = 1'b1;
        tick(3);
        check("t1_valid_early", 32'(m_valid), 0);
        tick(1);
        check("t1_valid_latency", 32'(m_valid), 1);
        tick(4);
        check("t1_drained", 32'(exp_q.size()), 0);

        // 2: both-edge mode, rise then fall 10 cycles later on ch1
        do_reset(2'b10);
        signal_in[1] = 1'b1;
        tick(10);
        exp_q.push_back(rec(1'b0, 2'd1, 8'd10));
        signal_in[1] = 1'b0;
        tick(8);
        check("t2_drained", 32'(exp_q.size()), 0);

        // 3: four channels, simultaneous second edges 40 cycles after arming
        do_reset(2'b00);
        signal_in = 4'hF;
        tick(10);
        signal_in = 4'h0;
        tick(30);
        for (int i = 0; i < 4; i++) exp_q.push_back(rec(1'b0, 2'(i), 8'd40));
        p0 = pop_count;
        signal_in = 4'hF;
        tick(4);
        check("t3_first_valid", 32'(m_valid), 1);
        tick(4);
        check("t3_consecutive_pops", 32'(pop_count - p0), 4);
        check("t3_empty_after", 32'(m_valid), 0);
        check("t3_drained", 32'(exp_q.size()), 0);

        // 4: overflow on ch2 then a short interval
        do_reset(2'b00);
        signal_in[2] = 1'b1;
        tick(10);
        signal_in[2] = 1'b0;
        tick(290);
        exp_q.push_back(rec(1'b1, 2'd2, 8'd255));
        signal_in[2] = 1'b1;
        tick(2);
        signal_in[2] = 1'b0;
        tick(3);
        exp_q.push_back(rec(1'b0, 2'd2, 8'd5));
        signal_in[2] = 1'b1;
        tick(8);
        check("t4_drained", 32'(exp_q.size()), 0);

        // 5: backpressure, FIFO fill, holding full and one drop
        do_reset(2'b00);
        m_ready = 1'b0;
        for (int i = 0; i < 19; i++) begin
            signal_in[0] = 1'b1;
            tick(5);
            signal_in[0] = 1'b0;
            tick(5);
        end
        for (int i = 0; i < 17; i++) exp_q.push_back(rec(1'b0, 2'd0, 8'd10));
        tick(5);
        check("t5_level_full", 32'(fifo_level), 16);
        check("t5_drop_cnt", 32'(drop_cnt), 1);
        check("t5_valid_stalled", 32'(m_valid), 1);
        m_ready = 1'b1;
        tick(30);
        check("t5_level_empty", 32'(fifo_level), 0);
        check("t5_drained", 32'(exp_q.size()), 0);
        check("t5_drop_kept", 32'(drop_cnt), 1);

        // 6: asynchronous reset with records queued
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            signal_in[0] = 1'b1;
            tick(5);
            signal_in[0] = 1'b0;
            tick(5);
        end
        tick(5);
        check("t6_level_before", 32'(fifo_level), 5);
        check("t6_drop_before", 32'(drop_cnt), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(m_valid), 0);
        check("t6_async_level", 32'(fifo_level), 0);
        check("t6_async_drop", 32'(drop_cnt), 0);
        tick(2);
        rst_n = 1'b1;
        tick(4);
        signal_in[0] = 1'b1;
        tick(5);
        signal_in[0] = 1'b0;
        tick(10);
        check("t6_no_rec_after_arm", 32'(fifo_level), 0);
        check("t6_no_valid_after_arm", 32'(m_valid), 0);
        m_ready = 1'b1;
        exp_q.push_back(rec(1'b0, 2'd0, 8'd15));
        signal_in[0] = 1'b1;
        tick(8);
        check("t6_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
